// File: rtl/score_packetizer_if.sv
// Bus bundle between the score logic / UART TX FIFOs and score_packetizer.
// master = score logic and FIFO side, slave = the packetizer itself.
interface score_packetizer_if #(
    parameter int NUM_CH        = 2,
    parameter int PAYLOAD_BYTES = 3
);
    logic [7:0]                 board_ID;
    logic [8*PAYLOAD_BYTES-1:0] points;
    logic                       send_req;
    logic [NUM_CH-1:0]          ch_en;
    logic [NUM_CH-1:0]          tx_full;
    logic [8*NUM_CH-1:0]        tx_data;
    logic [NUM_CH-1:0]          wr_en;
    logic                       busy;
    logic                       pkt_done;
    logic                       req_drop;

    modport master (
        output board_ID, points, send_req, ch_en, tx_full,
        input  tx_data, wr_en, busy, pkt_done, req_drop
    );

    modport slave (
        input  board_ID, points, send_req, ch_en, tx_full,
        output tx_data, wr_en, busy, pkt_done, req_drop
    );
endinterface

// File: rtl/score_packetizer.sv
// Serialises board ID + score into NUM_CH UART TX FIFOs, each channel advancing on its own.
// Optional trailing XOR checksum byte: define SCORE_PACKETIZER_CHECKSUM_EN.
module score_packetizer #(
    parameter int NUM_CH        = 2,
    parameter int PAYLOAD_BYTES = 3
) (
    input logic               clk,
    input logic               rst,
    score_packetizer_if.slave bus
);

`ifdef SCORE_PACKETIZER_CHECKSUM_EN
    localparam int PKT_LEN = 2 + PAYLOAD_BYTES;
`else
    localparam int PKT_LEN = 1 + PAYLOAD_BYTES;
`endif
    localparam int IDX_W = $clog2(PKT_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    state_t            state;
    state_t            state_next;
    logic [7:0]        snap [PKT_LEN];
    logic [IDX_W-1:0]  idx [NUM_CH];
    logic [NUM_CH-1:0] done;
    logic [NUM_CH-1:0] wr_en;
    logic              req_drop_q;
    logic              accept;

    assign accept       = (state == IDLE) && bus.send_req && (bus.board_ID != 8'd0);
    assign bus.wr_en    = wr_en;
    assign bus.req_drop = req_drop_q;

`ifdef SCORE_PACKETIZER_CHECKSUM_EN
    logic [7:0] checksum;

    always_comb begin
        checksum = bus.board_ID;
        for (int b = 0; b < PAYLOAD_BYTES; b++) begin
            checksum = checksum ^ bus.points[8*b +: 8];
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The final SEND cycle, where every done bit is already set, never writes.
    always_comb begin
        state_next   = state;
        wr_en        = '0;
        bus.busy     = 1'b0;
        bus.pkt_done = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                bus.busy = 1'b1;
                if (&done) begin
                    state_next = DONE;
                end else begin
                    wr_en = ~done & ~bus.tx_full;
                end
            end
            DONE: begin
                bus.pkt_done = 1'b1;
                state_next   = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (rst) begin
            wr_en = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PKT_LEN; i++) begin
                snap[i] <= 8'd0;
            end
            for (int c = 0; c < NUM_CH; c++) begin
                idx[c] <= '0;
            end
            done       <= '0;
            req_drop_q <= 1'b0;
        end else begin
            req_drop_q <= bus.send_req && !accept;
            if (accept) begin
                snap[0] <= bus.board_ID;
                for (int b = 0; b < PAYLOAD_BYTES; b++) begin
                    snap[1+b] <= bus.points[8*(PAYLOAD_BYTES-1-b) +: 8];
                end
`ifdef SCORE_PACKETIZER_CHECKSUM_EN
                snap[PKT_LEN-1] <= checksum;
`endif
                for (int c = 0; c < NUM_CH; c++) begin
                    idx[c] <= '0;
                end
                done <= ~bus.ch_en;
            end else if (state == SEND) begin
                // idx parks on the last byte so tx_data stays defined once a channel finishes
                for (int c = 0; c < NUM_CH; c++) begin
                    if (wr_en[c]) begin
                        if (idx[c] == LAST_IDX) begin
                            done[c] <= 1'b1;
                        end else begin
                            idx[c] <= idx[c] + 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        bus.tx_data = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            bus.tx_data[8*c +: 8] = snap[idx[c]];
        end
    end

endmodule

// File: tb/tb_score_packetizer.sv
// Scoreboard bench for score_packetizer: the driver queues expected bytes per channel,
// pkt_done deadlines and dropped requests; a negedge monitor pops and compares.
module tb_score_packetizer;

    localparam int NUM_CH        = 2;
    localparam int PAYLOAD_BYTES = 3;
`ifdef SCORE_PACKETIZER_CHECKSUM_EN
    localparam int PKT_LEN = 2 + PAYLOAD_BYTES;
`else
    localparam int PKT_LEN = 1 + PAYLOAD_BYTES;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   tests = 0;
    int   errors = 0;
    int   exp_drops = 0;

    logic [7:0] exp_q [NUM_CH][$];
    int         exp_done_q [$];

    score_packetizer_if #(.NUM_CH(NUM_CH), .PAYLOAD_BYTES(PAYLOAD_BYTES)) bus ();

    score_packetizer #(.NUM_CH(NUM_CH), .PAYLOAD_BYTES(PAYLOAD_BYTES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, actual, expected, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flushModel();
        exp_done_q.delete();
        for (int c = 0; c < NUM_CH; c++) begin
            exp_q[c].delete();
        end
    endtask

    // Reference packet: ID, score MSB first, optional XOR of everything before it.
    task automatic applyStimulus(input logic [7:0] id, input logic [23:0] pts,
                                 input logic [NUM_CH-1:0] en, input bit timed);
        int pkt [PKT_LEN];
        int sum;
        pkt[0] = id;
        sum    = id;
        for (int b = 0; b < PAYLOAD_BYTES; b++) begin
            pkt[1+b] = (pts >> (8 * (PAYLOAD_BYTES - 1 - b))) % 256;
            sum      = sum ^ pkt[1+b];
        end
`ifdef SCORE_PACKETIZER_CHECKSUM_EN
        pkt[PKT_LEN-1] = sum;
`endif
        bus.board_ID = id;
        bus.points   = pts;
        bus.ch_en    = en;
        bus.send_req = 1'b1;
        if (id == 8'd0) begin
            exp_drops++;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (en[c]) begin
                    for (int i = 0; i < PKT_LEN; i++) begin
                        exp_q[c].push_back(8'(pkt[i]));
                    end
                end
            end
        end
        tick();
        bus.send_req = 1'b0;
        bus.board_ID = 8'($urandom);
        bus.points   = 24'($urandom);
        bus.ch_en    = NUM_CH'($urandom);
        if (id != 8'd0) begin
            if (!timed) begin
                exp_done_q.push_back(-1);
            end else if (en == '0) begin
                exp_done_q.push_back(cyc + 1);
            end else begin
                exp_done_q.push_back(cyc + PKT_LEN + 1);
            end
            checkOutput("busy after capture", 32'(bus.busy), 32'd1);
        end
    endtask

    task automatic waitDone(input bit rand_stall, input bit extra_req);
        int n = 0;
        while (exp_done_q.size() != 0 && n < 300) begin
            if (rand_stall) begin
                bus.tx_full = NUM_CH'($urandom);
            end
            bus.send_req = extra_req && (n == 2);
            if (bus.send_req) begin
                exp_drops++;
            end
            tick();
            n++;
        end
        bus.send_req = 1'b0;
        bus.tx_full  = '0;
        checkOutput("packet finished within budget", 32'(exp_done_q.size()), 32'd0);
        flushModel();
        tick();
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (bus.wr_en[c]) begin
                    checkOutput($sformatf("ch%0d no write while full", c), 32'(bus.tx_full[c]), 32'd0);
                    if (exp_q[c].size() == 0) begin
                        checkOutput($sformatf("ch%0d write was expected", c), 32'(exp_q[c].size()), 32'd1);
                    end else begin
                        checkOutput($sformatf("ch%0d byte", c), 32'(bus.tx_data[8*c +: 8]), 32'(exp_q[c].pop_front()));
                    end
                end
            end
            if (bus.pkt_done) begin
                checkOutput("busy low in DONE", 32'(bus.busy), 32'd0);
                if (exp_done_q.size() == 0) begin
                    checkOutput("pkt_done was expected", 32'(exp_done_q.size()), 32'd1);
                end else begin
                    int due;
                    due = exp_done_q.pop_front();
                    if (due >= 0) begin
                        checkOutput("pkt_done cycle", 32'(cyc), 32'(due));
                    end
                    for (int c = 0; c < NUM_CH; c++) begin
                        checkOutput($sformatf("ch%0d complete at pkt_done", c), 32'(exp_q[c].size()), 32'd0);
                    end
                end
            end
            if (bus.req_drop) begin
                checkOutput("req_drop was expected", 32'(exp_drops > 0), 32'd1);
                if (exp_drops > 0) begin
                    exp_drops--;
                end
            end
        end
    end

    initial begin
        int n;
        bus.board_ID = '0;
        bus.points   = '0;
        bus.send_req = 1'b0;
        bus.ch_en    = '0;
        bus.tx_full  = '0;
        repeat (3) tick();
        checkOutput("reset wr_en", 32'(bus.wr_en), 32'd0);
        checkOutput("reset tx_data", 32'(bus.tx_data), 32'd0);
        checkOutput("reset busy", 32'(bus.busy), 32'd0);
        checkOutput("reset pkt_done", 32'(bus.pkt_done), 32'd0);
        checkOutput("reset req_drop", 32'(bus.req_drop), 32'd0);
        rst = 1'b0;
        tick();

        $display("[TB] basic send");
        applyStimulus(8'h05, 24'h123456, 2'b11, 1'b1);
        waitDone(1'b0, 1'b0);

        $display("[TB] backpressure on channel 1");
        applyStimulus(8'h05, 24'h123456, 2'b11, 1'b0);
        n = 0;
        while (exp_q[1].size() != PKT_LEN - 2 && n < 20) begin
            tick();
            n++;
        end
        bus.tx_full = 2'b10;
        repeat (3) tick();
        bus.tx_full = 2'b00;
        waitDone(1'b0, 1'b0);

        $display("[TB] guard cases");
        applyStimulus(8'h00, 24'h111111, 2'b11, 1'b1);
        repeat (2) tick();
        applyStimulus(8'h07, 24'h00FF01, 2'b11, 1'b1);
        waitDone(1'b0, 1'b1);

        $display("[TB] channel mask and snapshot");
        applyStimulus(8'h09, 24'hABCDEF, 2'b01, 1'b1);
        bus.points = 24'h000000;
        waitDone(1'b0, 1'b0);
        applyStimulus(8'h0A, 24'h445566, 2'b00, 1'b1);
        waitDone(1'b0, 1'b0);

        $display("[TB] reset mid-packet");
        applyStimulus(8'h21, 24'h313233, 2'b11, 1'b0);
        n = 0;
        while (exp_q[0].size() != PKT_LEN - 2 && n < 20) begin
            tick();
            n++;
        end
        rst = 1'b1;
        #1;
        checkOutput("wr_en forced low in reset", 32'(bus.wr_en), 32'd0);
        flushModel();
        tick();
        rst = 1'b0;
        checkOutput("busy after reset", 32'(bus.busy), 32'd0);
        checkOutput("pkt_done after reset", 32'(bus.pkt_done), 32'd0);
        repeat (4) tick();
        applyStimulus(8'h22, 24'hC0FFEE, 2'b11, 1'b1);
        waitDone(1'b0, 1'b0);

        $display("[TB] randomized packets");
        for (int k = 0; k < 30; k++) begin
            logic [7:0]        id;
            logic [NUM_CH-1:0] en;
            bit                stall;
            id    = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
            en    = NUM_CH'($urandom);
            stall = $urandom_range(0, 1) == 1;
            applyStimulus(id, 24'($urandom), en, !stall);
            if (id == 8'h00) begin
                repeat (2) tick();
            end else begin
                waitDone(stall, $urandom_range(0, 2) == 0);
            end
        end

        repeat (4) tick();
        checkOutput("all dropped requests reported", 32'(exp_drops), 32'd0);
        checkOutput("no pending packets", 32'(exp_done_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
